// File: rtl/seg_display_scanner_pkg.sv
// bd_display_pkg: shared types and constants for the seven-segment scanner.
package bd_display_pkg;
    typedef enum logic {BLANK, SHOW} scan_state_t;
    typedef logic [1:0] digit_idx_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;
endpackage

// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if: pattern/control inputs and panel outputs of the scanner.
// i_seven_seg1..4 : segment patterns for digits 0..3, active-high, bit 6 = g .. bit 0 = a
// i_load          : capture the four patterns into the pending buffer
// i_drop_activated: enables panel blinking
// o_seg_n         : shared segment bus, active-low
// o_an_n          : digit enables, active-low, one-hot when lit
// o_frame_done    : pulse on the last clock of the digit-3 window
interface seg_display_scanner_if;
    logic [6:0] i_seven_seg1;
    logic [6:0] i_seven_seg2;
    logic [6:0] i_seven_seg3;
    logic [6:0] i_seven_seg4;
    logic       i_load;
    logic       i_drop_activated;
    logic [6:0] o_seg_n;
    logic [3:0] o_an_n;
    logic       o_frame_done;
    modport master (
        output i_seven_seg1, i_seven_seg2, i_seven_seg3, i_seven_seg4, i_load, i_drop_activated,
        input  o_seg_n, o_an_n, o_frame_done
    );
    modport slave (
        input  i_seven_seg1, i_seven_seg2, i_seven_seg3, i_seven_seg4, i_load, i_drop_activated,
        output o_seg_n, o_an_n, o_frame_done
    );
endinterface

// File: rtl/seg_display_scanner_digit_timer.sv
// display_digit_timer: window counter and digit index for the scanner.
// clk, rst_n         : clock, asynchronous active-low reset
// o_state_nxt        : BLANK/SHOW for the coming cycle
// o_dig_nxt          : digit index for the coming cycle
// o_frame_end        : current cycle is the last of the digit-3 window
// o_frame_end_nxt    : coming cycle is the last of the digit-3 window
// The "_nxt" outputs let the parent register its outputs so they line up
// with the counter value of the same cycle.
module display_digit_timer
    import bd_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output scan_state_t o_state_nxt,
    output digit_idx_t  o_dig_nxt,
    output logic        o_frame_end,
    output logic        o_frame_end_nxt
);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] LAST      = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    digit_idx_t    r_dig;
    logic          w_last_in_window;

    assign w_last_in_window = r_cnt == LAST;
    assign o_frame_end      = w_last_in_window && r_dig == 2'd3;
    assign w_cnt_nxt        = w_last_in_window ? '0 : r_cnt + 1'b1;
    assign o_dig_nxt        = w_last_in_window ? r_dig + 1'b1 : r_dig;
    assign o_state_nxt      = w_cnt_nxt < BLANK_END ? BLANK : SHOW;
    assign o_frame_end_nxt  = w_cnt_nxt == LAST && o_dig_nxt == 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dig <= o_dig_nxt;
        end
    end
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: double-buffered, blanked, blinking 4-digit seven-segment scanner.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of seg_display_scanner_if (patterns, load, blink enable in;
//              seg_n, an_n, frame_done out)
module seg_display_scanner
    import bd_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_display_scanner_if.slave bus
);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0][6:0] w_in;
    logic [3:0][6:0] r_pending;
    logic [3:0][6:0] r_active;
    logic [3:0][6:0] w_active_nxt;
    logic            r_pend_valid;
    logic            r_blink_dark;
    logic            w_dark_nxt;
    logic [FW-1:0]   r_fcnt;
    logic [FW-1:0]   w_fcnt_nxt;
    logic            w_wrap;
    logic            w_lit;
    scan_state_t     w_state_nxt;
    digit_idx_t      w_dig_nxt;
    logic            w_frame_end;
    logic            w_frame_end_nxt;

    display_digit_timer #(
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_state_nxt    (w_state_nxt),
        .o_dig_nxt      (w_dig_nxt),
        .o_frame_end    (w_frame_end),
        .o_frame_end_nxt(w_frame_end_nxt)
    );

    assign w_in = {bus.i_seven_seg4, bus.i_seven_seg3, bus.i_seven_seg2, bus.i_seven_seg1};

    // A load coinciding with the frame boundary bypasses pending so the new
    // patterns still land on the very next frame.
    always_comb begin
        w_active_nxt = !w_frame_end ? r_active : bus.i_load ? w_in : r_pend_valid ? r_pending : r_active;
        w_wrap       = r_fcnt == FW'(BLINK_FRAMES - 1);
        w_fcnt_nxt   = !bus.i_drop_activated ? '0 : !w_frame_end ? r_fcnt : w_wrap ? '0 : r_fcnt + 1'b1;
        w_dark_nxt   = bus.i_drop_activated && (r_blink_dark ^ (w_frame_end && w_wrap));
        w_lit        = w_state_nxt == SHOW && !w_dark_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending        <= '0;
            r_active         <= '0;
            r_pend_valid     <= 1'b0;
            r_fcnt           <= '0;
            r_blink_dark     <= 1'b0;
            bus.o_an_n       <= AN_OFF;
            bus.o_seg_n      <= SEG_OFF;
            bus.o_frame_done <= 1'b0;
        end else begin
            if (bus.i_load)
                r_pending <= w_in;
            r_pend_valid     <= bus.i_load ? !w_frame_end : r_pend_valid && !w_frame_end;
            r_active         <= w_active_nxt;
            r_fcnt           <= w_fcnt_nxt;
            r_blink_dark     <= w_dark_nxt;
            bus.o_an_n       <= w_lit ? ~(4'b0001 << w_dig_nxt) : AN_OFF;
            bus.o_seg_n      <= w_lit ? ~w_active_nxt[w_dig_nxt] : SEG_OFF;
            bus.o_frame_done <= w_frame_end_nxt;
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: scoreboard bench for seg_display_scanner.
module tb_seg_display_scanner;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 4 * DC;
    localparam logic [27:0] PAT_A = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] PAT_F = {4{7'h3F}};
    localparam logic [27:0] PAT_B = {7'h5E, 7'h39, 7'h7C, 7'h77};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_scanner_if bus();

    seg_display_scanner #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic set_pat(input logic [27:0] p);
        bus.i_seven_seg1 = p[6:0];
        bus.i_seven_seg2 = p[13:7];
        bus.i_seven_seg3 = p[20:14];
        bus.i_seven_seg4 = p[27:21];
    endtask

    // Expected frame from the panel description: cycles c <= dark_until are dark.
    task automatic push_frame(input logic [27:0] p, input int dark_until);
        for (int c = 0; c < FR; c++) begin
            int d;
            int k;
            bit lit;
            exp_t e;
            d = c / DC;
            k = c % DC;
            lit = (k >= BC) && (c > dark_until);
            e.an = lit ? ~(4'b0001 << d) : 4'hF;
            e.seg = lit ? ~p[d*7 +: 7] : 7'h7F;
            e.fd = (c == FR - 1);
            q.push_back(e);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
                errors++;
                $display("FAIL reset i=%0d got an=%b seg=%h fd=%b want an=1111 seg=7f fd=0",
                         i, bus.o_an_n, bus.o_seg_n, bus.o_frame_done);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_display;
        exp_t e;
        push_frame('0, -1);
        push_frame(PAT_A, -1);
        for (int c = 0; c < 2 * FR; c++) begin
            bus.i_load = (c == 5);
            if (c == 5) set_pat(PAT_A);
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL load_display c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_midframe_reload;
        exp_t e;
        push_frame(PAT_A, -1);
        push_frame(PAT_F, -1);
        for (int c = 0; c < 2 * FR; c++) begin
            bus.i_load = (c == 12);
            if (c == 12) set_pat(PAT_F);
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL midframe_reload c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundary_load;
        exp_t e;
        push_frame(PAT_F, -1);
        push_frame(PAT_B, -1);
        push_frame(PAT_B, -1);
        for (int c = 0; c < 3 * FR; c++) begin
            bus.i_load = (c == FR - 1);
            if (c == FR - 1) set_pat(PAT_B);
            if (c == FR + 8) set_pat(PAT_A);
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL boundary_load c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_blink;
        exp_t e;
        push_frame(PAT_B, -1);
        push_frame(PAT_B, -1);
        push_frame(PAT_B, FR - 1);
        push_frame(PAT_B, 12);
        push_frame(PAT_B, -1);
        for (int c = 0; c < 5 * FR; c++) begin
            bus.i_drop_activated = (c < 3 * FR + 12);
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL blink c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_show;
        exp_t e;
        push_frame(PAT_B, -1);
        for (int c = 0; c <= 2 * DC + 4; c++) begin
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL pre_reset c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            if (c < 2 * DC + 4) begin
                @(posedge clk); #1;
            end
        end
        q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%h fd=%b want an=1111 seg=7f fd=0",
                     bus.o_an_n, bus.o_seg_n, bus.o_frame_done);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame('0, -1);
        for (int c = 0; c < FR; c++) begin
            e = q.pop_front();
            checks++;
            if ({bus.o_an_n, bus.o_seg_n, bus.o_frame_done} !== e) begin
                errors++;
                $display("FAIL post_reset c=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                         c, bus.o_an_n, bus.o_seg_n, bus.o_frame_done, e.an, e.seg, e.fd);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.i_load = 1'b0;
        bus.i_drop_activated = 1'b0;
        set_pat('0);
        test_reset;
        test_load_display;
        test_midframe_reload;
        test_boundary_load;
        test_blink;
        test_reset_mid_show;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed driver for the four-digit seven-segment panel at the output end of the baggage-drop datapath. It accepts the four 7-bit segment patterns produced upstream plus the drop-activated flag, double-buffers them, and scans them onto a single shared segment bus with per-digit enables. The block inserts ghost-suppression blanking between digits and blinks the whole panel while a drop is active.

## Interface
- `DIGIT_CYCLES`, default 1000: clocks per digit window, including blanking; must be at least 2.
- `BLANK_CYCLES`, default 16: blanked clocks at the start of each window; must be at least 1 and less than `DIGIT_CYCLES`.
- `BLINK_FRAMES`, default 250: full frames per blink half-period; must be at least 1.
- `clk`, input, 1: single clock for the whole block.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `seven_seg1`..`seven_seg4`, input, 7 each: segment patterns, active-high, bit 6 = segment g … bit 0 = segment a. `seven_seg1` maps to digit 0 and `seven_seg4` to digit 3.
- `load`, input, 1: captures the four patterns on the rising edge where it is high.
- `drop_activated`, input, 1: high enables the blink mode.
- `seg_n`, output, 7: shared segment bus, active-low.
- `an_n`, output, 4: digit enables, active-low, one-hot when driven; `an_n[i]` selects digit i.
- `frame_done`, output, 1: one-cycle pulse on the last clock of the digit-3 window.

## Operation
- **Buffers.**
  - `pending[0:3]`, `active[0:3]` (7 bits each) and a `pend_valid` flag.
  - `load=1` writes the inputs into `pending` and sets `pend_valid`.
  - On the frame-boundary edge (end of the digit-3 window), if `pend_valid=1`, `pending` is copied to `active` and `pend_valid` is cleared.
- **Simultaneous load and boundary.** The inputs go directly to `active`, `pending` is also written, and `pend_valid` ends at 0. The new data is displayed from digit 0 of the next frame.
- **Scan FSM.** States are BLANK and SHOW, with digit index `dig` running 0..3 and window counter `cnt` running 0..DIGIT_CYCLES-1.
  - BLANK while `cnt < BLANK_CYCLES`, otherwise SHOW.
  - At `cnt = DIGIT_CYCLES-1`: `cnt` goes to 0, `dig` goes to `dig+1`, wrapping 3→0, and the state returns to BLANK.
- **Outputs.**
  - BLANK: `an_n=4'hF`, `seg_n=7'h7F`.
  - SHOW: `an_n[dig]=0` with the other bits at 1, and `seg_n = ~active[dig]`.
- **Blink.**
  - Frame counter `fcnt` runs 0..BLINK_FRAMES-1 and toggles `blink_dark` on wrap at each frame boundary.
  - While `blink_dark=1`, SHOW drives the same values as BLANK.
  - While `drop_activated=0`, `fcnt` and `blink_dark` are held at 0.
  - `drop_activated` is sampled every clock, so deasserting it restores lit SHOW windows from the next clock onward.
- **Reset values.** `cnt=0`, `dig=0`, `fcnt=0`, `blink_dark=0`, `active` and `pending` all 0, `pend_valid=0`. Outputs reset to `an_n=4'hF`, `seg_n=7'h7F`, `frame_done=0`.

## Timing
- All outputs are registered and reflect the `cnt`/`dig` value of the same cycle; there is no additional pipeline stage.
- The first clock after `rst_n` deasserts is cycle 0 of the digit-0 window.
- One frame is 4·DIGIT_CYCLES clocks. `frame_done` is high exactly when `dig=3` and `cnt=DIGIT_CYCLES-1`.
- Load-to-display latency: new data appears at cycle `BLANK_CYCLES` of the next digit-0 window after the next frame boundary, never mid-frame. This prevents tearing.
- Blink period: 2·BLINK_FRAMES frames, split into equal lit and dark halves. The first half after `drop_activated` rises is lit.
- Reset asserted mid-operation blanks the outputs immediately (asynchronously) and discards both buffers.

## Structure
- Package `bd_display_pkg` holds:
  - the `scan_state_t` enum (BLANK, SHOW);
  - the `digit_idx_t` typedef (2 bits);
  - the constants `SEG_OFF = 7'h7F` and `AN_OFF = 4'hF`.
- One sub-module is natural: `display_digit_timer`, which owns `cnt` and `dig` and emits `show`, `last_in_window` and `frame_end`.
- Counter widths are `$clog2` of the corresponding parameter.

## Test plan
Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- **Reset.** Hold `rst_n=0` for 5 clocks, then release. Required: `an_n=F`, `seg_n=7F` and `frame_done=0` throughout reset; because the buffers are 0, the panel stays dark. The first `frame_done` pulse occurs on clock 31 after release.
- **Load and display.** Load 06/5B/4F/66 during frame 0. Required in frame 1:
  - digit 0: `an_n=1110`, `seg_n=79` on cycles 2–7 of the window;
  - digits 1–3: `seg_n` = 24, 30, 19 respectively;
  - cycles 0–1 of every window are blank.
- **Mid-frame reload.** Load 3F ×4 on cycle 12 of frame 1. Required: frame 1 still shows the old patterns; frame 2 shows `seg_n=40` on every digit.
- **Load on the boundary.** Pulse `load` in the cycle where `frame_done=1`. Required: the next frame shows the new values and `pend_valid` ends at 0.
- **Blink.** Raise `drop_activated` at a frame start. Required: frames alternate 2 lit, 2 dark (all outputs blank in dark frames). Lowering it during a dark frame makes the following SHOW cycles lit.
- **Reset mid-SHOW.** Pull `rst_n` low on cycle 4 of digit 2. Required: outputs go to `F`/`7F` before the next edge, and the panel stays dark after release until the next load.
